// File: rtl/adsr_envelope.sv
// Four-stage ADSR envelope generator for one synth voice.
// Level moves once per prescaler tick; gate edges switch stage immediately.
module adsr_envelope #(
  parameter int LEVEL_W  = 8,
  parameter int TICK_DIV = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gate,
  input  logic [3:0]         attack,
  input  logic [3:0]         decay,
  input  logic [3:0]         sustain,
  input  logic [3:0]         release_rate,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         stage,
  output logic               busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [LEVEL_W:0] FULL_SCALE = {1'b0, {LEVEL_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } stage_t;

  stage_t               stage_q, stage_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 busy_q;
  logic [CNT_W-1:0]     presc_q;
  logic                 tick;

  logic [LEVEL_W:0]     atk_step, dec_step, rel_step;
  logic [LEVEL_W:0]     atk_sum, dec_diff, rel_diff;
  logic [LEVEL_W-1:0]   target;

  assign tick = (presc_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + CNT_W'(1);
    end
  end

  // Steps are control+1; all arithmetic is one bit wider so carry/borrow is visible.
  assign atk_step = {{(LEVEL_W-3){1'b0}}, attack}       + {{LEVEL_W{1'b0}}, 1'b1};
  assign dec_step = {{(LEVEL_W-3){1'b0}}, decay}        + {{LEVEL_W{1'b0}}, 1'b1};
  assign rel_step = {{(LEVEL_W-3){1'b0}}, release_rate} + {{LEVEL_W{1'b0}}, 1'b1};

  assign atk_sum  = {1'b0, level_q} + atk_step;
  assign dec_diff = {1'b0, level_q} - dec_step;
  assign rel_diff = {1'b0, level_q} - rel_step;

  assign target = {sustain, sustain};

  always_comb begin
    stage_d = stage_q;
    level_d = level_q;
    unique case (stage_q)
      S_IDLE: begin
        if (gate) begin
          stage_d = S_ATTACK;
        end else if (tick) begin
          level_d = '0;
        end
      end
      S_ATTACK: begin
        if (!gate) begin
          stage_d = S_RELEASE;
        end else if (tick) begin
          if (atk_sum >= FULL_SCALE) begin
            level_d = FULL_SCALE[LEVEL_W-1:0];
            stage_d = S_DECAY;
          end else begin
            level_d = atk_sum[LEVEL_W-1:0];
          end
        end
      end
      S_DECAY: begin
        if (!gate) begin
          stage_d = S_RELEASE;
        end else if (tick) begin
          if (dec_diff[LEVEL_W] || (dec_diff[LEVEL_W-1:0] <= target)) begin
            level_d = target;
            stage_d = S_SUSTAIN;
          end else begin
            level_d = dec_diff[LEVEL_W-1:0];
          end
        end
      end
      S_SUSTAIN: begin
        if (!gate) begin
          stage_d = S_RELEASE;
        end else if (tick) begin
          level_d = target;
        end
      end
      S_RELEASE: begin
        if (gate) begin
          stage_d = S_ATTACK;
        end else if (tick) begin
          if (rel_diff[LEVEL_W] || (rel_diff[LEVEL_W-1:0] == '0)) begin
            level_d = '0;
            stage_d = S_IDLE;
          end else begin
            level_d = rel_diff[LEVEL_W-1:0];
          end
        end
      end
      default: begin
        stage_d = S_IDLE;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= S_IDLE;
      level_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      level_q <= level_d;
      busy_q  <= (stage_d != S_IDLE);
    end
  end

  assign level = level_q;
  assign stage = stage_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with a short prescaler (TICK_DIV=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adsr_envelope;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       gate;
  logic [3:0] attack, decay, sustain, release_rate;
  logic [7:0] level;
  logic [2:0] stage;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int pc          = 0;

  adsr_envelope #(.LEVEL_W(8), .TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .gate         (gate),
    .attack       (attack),
    .decay        (decay),
    .sustain      (sustain),
    .release_rate (release_rate),
    .level        (level),
    .stage        (stage),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Bench-side prescaler model: value the DUT counter holds at the coming edge.
  always @(posedge clk) begin
    if (rst) pc <= 0;
    else     pc <= (pc == TD-1) ? 0 : pc + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout level=%0d stage=%0d required=finish", level, stage);
    $fatal(1, "[TB] timeout");
  end

  task automatic next_tick;
    int guard = 0;
    while (pc != TD-1 && guard < 2*TD) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
  endtask

  task automatic wait_tick_edge;
    int guard = 0;
    while (pc != TD-1 && guard < 2*TD) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst  = 1'b1;
    gate = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  task automatic test_reset;
    gate = 0; attack = 0; decay = 0; sustain = 0; release_rate = 0; rst = 0;
    do_reset();
    vectors++; if (level !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    vectors++; if (stage !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_stage got=%0d exp=0", stage); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_attack;
    attack = 15; decay = 15; sustain = 8; release_rate = 0;
    gate = 1'b1;
    @(negedge clk);
    vectors++; if (stage !== 3'd1) begin miscompares++; $display("[TB] FAIL atk_enter_stage got=%0d exp=1", stage); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL atk_enter_busy got=%0b exp=1", busy); end
    vectors++; if (level !== 8'd0) begin miscompares++; $display("[TB] FAIL atk_enter_level got=%0d exp=0", level); end
    @(negedge clk);
    @(negedge clk);
    vectors++; if (level !== 8'd0) begin miscompares++; $display("[TB] FAIL atk_pretick_level got=%0d exp=0", level); end
    @(negedge clk);
    vectors++; if (level !== 8'd16) begin miscompares++; $display("[TB] FAIL atk_tick1_level got=%0d exp=16", level); end
    for (int k = 2; k <= 15; k++) begin
      next_tick();
      vectors++; if (level !== 8'(16*k) || stage !== 3'd1) begin
        miscompares++; $display("[TB] FAIL atk_tick%0d got level=%0d stage=%0d exp level=%0d stage=1", k, level, stage, 16*k);
      end
    end
    next_tick();
    vectors++; if (level !== 8'd255 || stage !== 3'd2) begin
      miscompares++; $display("[TB] FAIL atk_peak got level=%0d stage=%0d exp level=255 stage=2", level, stage);
    end
  endtask

  task automatic test_decay;
    for (int k = 1; k <= 7; k++) begin
      next_tick();
      vectors++; if (level !== 8'(255 - 16*k) || stage !== 3'd2) begin
        miscompares++; $display("[TB] FAIL dec_tick%0d got level=%0d stage=%0d exp level=%0d stage=2", k, level, stage, 255-16*k);
      end
    end
    next_tick();
    vectors++; if (level !== 8'd136 || stage !== 3'd3) begin
      miscompares++; $display("[TB] FAIL dec_settle got level=%0d stage=%0d exp level=136 stage=3", level, stage);
    end
    next_tick();
    vectors++; if (level !== 8'd136 || stage !== 3'd3) begin
      miscompares++; $display("[TB] FAIL sus_hold got level=%0d stage=%0d exp level=136 stage=3", level, stage);
    end
    sustain = 4;
    next_tick();
    vectors++; if (level !== 8'd68 || stage !== 3'd3) begin
      miscompares++; $display("[TB] FAIL sus_change got level=%0d stage=%0d exp level=68 stage=3", level, stage);
    end
    sustain = 8;
    next_tick();
    vectors++; if (level !== 8'd136) begin miscompares++; $display("[TB] FAIL sus_restore got=%0d exp=136", level); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rst = 1'b1; gate = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (level !== 8'd0 || stage !== 3'd0 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_mid got level=%0d stage=%0d busy=%0b exp 0/0/0", level, stage, busy);
    end
    attack = 7; gate = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (level !== 8'd0 || stage !== 3'd1) begin
      miscompares++; $display("[TB] FAIL rst_presc_early got level=%0d stage=%0d exp level=0 stage=1", level, stage);
    end
    @(negedge clk);
    vectors++; if (level !== 8'd8) begin miscompares++; $display("[TB] FAIL rst_presc_tick got=%0d exp=8", level); end
  endtask

  task automatic reach_sustain_136;
    do_reset();
    attack = 15; decay = 15; sustain = 8; release_rate = 0;
    gate = 1'b1;
    repeat (24) next_tick();
    vectors++; if (level !== 8'd136 || stage !== 3'd3) begin
      miscompares++; $display("[TB] FAIL reach_sus got level=%0d stage=%0d exp level=136 stage=3", level, stage);
    end
  endtask

  task automatic test_release;
    reach_sustain_136();
    release_rate = 0;
    gate = 1'b0;
    @(negedge clk);
    vectors++; if (stage !== 3'd4 || level !== 8'd136 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL rel_enter got level=%0d stage=%0d busy=%0b exp 136/4/1", level, stage, busy);
    end
    for (int k = 1; k <= 135; k++) begin
      next_tick();
      vectors++; if (level !== 8'(136 - k) || stage !== 3'd4) begin
        miscompares++; $display("[TB] FAIL rel_tick%0d got level=%0d stage=%0d exp level=%0d stage=4", k, level, stage, 136-k);
      end
    end
    next_tick();
    vectors++; if (level !== 8'd0 || stage !== 3'd0 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rel_idle got level=%0d stage=%0d busy=%0b exp 0/0/0", level, stage, busy);
    end
  endtask

  task automatic test_retrigger;
    reach_sustain_136();
    release_rate = 0;
    gate = 1'b0;
    @(negedge clk);
    repeat (36) next_tick();
    vectors++; if (level !== 8'd100 || stage !== 3'd4) begin
      miscompares++; $display("[TB] FAIL retrig_pre got level=%0d stage=%0d exp level=100 stage=4", level, stage);
    end
    wait_tick_edge();
    attack = 3; gate = 1'b1;
    @(negedge clk);
    vectors++; if (stage !== 3'd1 || level !== 8'd100) begin
      miscompares++; $display("[TB] FAIL retrig_edge got level=%0d stage=%0d exp level=100 stage=1", level, stage);
    end
    next_tick();
    vectors++; if (level !== 8'd104 || stage !== 3'd1) begin
      miscompares++; $display("[TB] FAIL retrig_tick got level=%0d stage=%0d exp level=104 stage=1", level, stage);
    end
    wait_tick_edge();
    gate = 1'b0;
    @(negedge clk);
    vectors++; if (stage !== 3'd4 || level !== 8'd104) begin
      miscompares++; $display("[TB] FAIL drop_on_tick got level=%0d stage=%0d exp level=104 stage=4", level, stage);
    end
    next_tick();
    vectors++; if (level !== 8'd103) begin miscompares++; $display("[TB] FAIL drop_rel_tick got=%0d exp=103", level); end
  endtask

  task automatic test_clamps;
    do_reset();
    attack = 15; decay = 15; sustain = 15; release_rate = 0;
    gate = 1'b1;
    repeat (16) next_tick();
    vectors++; if (level !== 8'd255 || stage !== 3'd2) begin
      miscompares++; $display("[TB] FAIL clamp15_peak got level=%0d stage=%0d exp level=255 stage=2", level, stage);
    end
    next_tick();
    vectors++; if (level !== 8'd255 || stage !== 3'd3) begin
      miscompares++; $display("[TB] FAIL clamp15_sus got level=%0d stage=%0d exp level=255 stage=3", level, stage);
    end
    do_reset();
    sustain = 0;
    gate = 1'b1;
    repeat (16) next_tick();
    for (int k = 1; k <= 15; k++) begin
      next_tick();
      vectors++; if (level !== 8'(255 - 16*k) || stage !== 3'd2) begin
        miscompares++; $display("[TB] FAIL clamp0_dec%0d got level=%0d stage=%0d exp level=%0d stage=2", k, level, stage, 255-16*k);
      end
    end
    next_tick();
    vectors++; if (level !== 8'd0 || stage !== 3'd3 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL clamp0_sus got level=%0d stage=%0d busy=%0b exp 0/3/1", level, stage, busy);
    end
    next_tick();
    vectors++; if (level !== 8'd0 || stage !== 3'd3 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL clamp0_hold got level=%0d stage=%0d busy=%0b exp 0/3/1", level, stage, busy);
    end
    gate = 1'b0;
    @(negedge clk);
    vectors++; if (stage !== 3'd4 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL clamp0_rel got stage=%0d busy=%0b exp 4/1", stage, busy);
    end
    next_tick();
    vectors++; if (level !== 8'd0 || stage !== 3'd0 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL clamp0_idle got level=%0d stage=%0d busy=%0b exp 0/0/0", level, stage, busy);
    end
  endtask

  initial begin
    $display("[TB] adsr_envelope directed tests, TICK_DIV=%0d", TD);
    test_reset();
    test_attack();
    test_decay();
    test_reset_mid();
    test_release();
    test_retrigger();
    test_clamps();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Four-stage attack/decay/sustain/release envelope generator for one synth voice. It sits in the ADSR path directly upstream of the amplitude multiplier and consumes the team's subtractor arithmetic for decay and release steps. It produces an unsigned LEVEL_W-bit gain level that is updated once per envelope tick, driven by a note gate and four 4-bit rate/level controls.

## Interface
- LEVEL_W, 8: envelope level width, in bits. Fixed at 8 in this revision.
- TICK_DIV, 256: clock cycles per envelope tick, minimum 2.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- gate  in  1  note held (1) / released (0); level-sensitive, sampled every clk.
- attack  in  4  attack step minus 1, so step = attack+1.
- decay  in  4  decay step minus 1, so step = decay+1.
- sustain  in  4  sustain level; target = {sustain, sustain}, i.e. sustain×17.
- release  in  4  release step minus 1, so step = release+1.
- level  out  LEVEL_W  current envelope level, registered.
- stage  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- busy  out  1  stage != IDLE, registered.

## Operation
- **Prescaler:** free-running counter, 0..TICK_DIV-1. `tick` is asserted internally while the counter equals TICK_DIV-1, then the counter wraps to 0.
- **Gate transitions:** these take effect on the clk edge where they are seen, not on the next tick. They have priority over the level update, so no level change occurs on that edge even if tick is high.
  - IDLE or RELEASE with gate=1 → ATTACK. Level is kept, with no restart from 0.
  - ATTACK, DECAY or SUSTAIN with gate=0 → RELEASE. Level is kept.
- **Per-tick level update**, when no gate transition fires:
  - ATTACK: sum = level + (attack+1), computed LEVEL_W+1 wide. If sum ≥ 255: level=255, → DECAY. Else level=sum.
  - DECAY: diff = level − (decay+1), LEVEL_W+1 wide with borrow. If borrow, or diff ≤ target: level=target, → SUSTAIN. Else level=diff.
  - SUSTAIN: level=target every tick, so a sustain change mid-note is followed on the next tick. Stays in SUSTAIN.
  - RELEASE: diff = level − (release+1). If borrow or diff==0: level=0, → IDLE. Else level=diff.
  - IDLE: level held at 0.
- **Boundary cases:**
  - sustain=15 (target 255): the first DECAY tick goes to SUSTAIN at 255.
  - sustain=0: DECAY settles at 0 in SUSTAIN and busy stays 1 until gate falls.
  - Gate re-asserted during RELEASE resumes ATTACK from the current level.
  - Level never wraps: saturating add, clamped subtract.
- Controls (attack, decay, sustain, release) are sampled only on tick edges. They need not be stable between ticks.

## Timing
- **Reset:** level=0, stage=IDLE, busy=0, prescaler=0, all on the first clk edge with rst=1.
- **Gate response:** stage changes on the edge after gate changes. busy follows the same edge.
- **Level latency:** level changes on the edge where tick=1 and is registered one cycle after the prescaler reaches TICK_DIV-1.
- **rst priority:** rst overrides everything, including mid-stage. Level returns to 0 immediately with no release ramp.
- **Stage durations:** at most 1 tick per step.
  - Full attack from 0 at step s: ceil(255/s) ticks.
  - Full release at step 1 from L: L ticks.

## Test plan
- **Reset mid-note:** reach SUSTAIN at 136, assert rst for 1 cycle → next cycle level=0, stage=0, busy=0, prescaler=0.
- **Attack:** TICK_DIV=4, attack=15, gate 0→1 → stage=1 on the next edge. Level 16, 32, … 240 on ticks 1–15. Tick 16: level=255, stage=2.
- **Decay to sustain:** decay=15, sustain=8 → from 255, levels 239, 223, 207, 191, 175, 159, 143. 8th tick: level=136, stage=3. Later ticks hold 136. Change sustain to 4 → next tick level=68.
- **Release to idle:** from SUSTAIN 136, release=0, gate→0 → stage=4 on the next edge. Level falls by 1 per tick. After 136 ticks: level=0, stage=0, busy=0.
- **Retrigger and simultaneous events:**
  - In RELEASE at level 100, raise gate on a tick edge → stage=1, level stays 100 on that edge, next tick level = 100+attack+1.
  - Drop gate during ATTACK coincident with tick → stage=4, level unchanged.
- **Clamps:** sustain=15 → DECAY goes to SUSTAIN on the first tick at 255. sustain=0, decay=15 → settles at 0 with busy=1.
